// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Write-back arbiter and load scoreboard for the single-write-port RV32I
// register file. ALU results and returning load data share one registered
// write port (rd / dist1 / reg_write). A one-entry holding buffer parks an
// ALU result that loses arbitration to the LSU. A pending vector marks
// registers with outstanding loads. Decode reads of stale registers raise
// stall.
//
// Optional feature macro: RF_WB_FWD_EN
//   Defined   : adds fwd1_valid/fwd1_data/fwd2_valid/fwd2_data. Hits on the
//               buffer or output register are forwarded. Only pending-load
//               hits stall.
//   Undefined : no forwarding ports. Every hit stalls.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   alu_valid/rd/data     ALU result offer; alu_ready accepts it
//   lsu_valid/rd/data     load data return, always accepted
//   ld_issue/ld_issue_rd  load issue, marks destination pending
//   rs1, rs2              decode read addresses
//   stall                 decode must hold
//   rd, dist1, reg_write  register file write port (registered)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            alu_valid,
   input  logic [RAW-1:0]  alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [RAW-1:0]  lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic            ld_issue,
   input  logic [RAW-1:0]  ld_issue_rd,
   input  logic [RAW-1:0]  rs1,
   input  logic [RAW-1:0]  rs2,
   output logic            stall,
`ifdef RF_WB_FWD_EN
   output logic            fwd1_valid,
   output logic [XLEN-1:0] fwd1_data,
   output logic            fwd2_valid,
   output logic [XLEN-1:0] fwd2_data,
`endif
   output logic [RAW-1:0]  rd,
   output logic [XLEN-1:0] dist1,
   output logic            reg_write
);

   localparam int NREG = 1 << RAW;
   localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};
   localparam logic [RAW-1:0]  ZERO_RD = {RAW{1'b0}};

   logic            buf_valid_r;
   logic [RAW-1:0]  buf_rd_r;
   logic [XLEN-1:0] buf_data_r;
   logic [NREG-1:0] pending_r;

   logic            grant_valid_s;
   logic [RAW-1:0]  grant_rd_s;
   logic [XLEN-1:0] grant_data_s;
   logic            buf_load_s;
   logic            buf_clear_s;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] clr_mask_s;
   logic [NREG-1:0] pending_next_s;

   logic pend1_s, pend2_s, buf1_s, buf2_s, out1_s, out2_s;

   // The buffer holds at most one result, so the ALU is blocked whenever it is full.
   assign alu_ready = ~buf_valid_r;

   // Fixed-priority grant: LSU, then the buffered ALU result, then the live ALU result.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_rd_s    = ZERO_RD;
      grant_data_s  = {XLEN{1'b0}};
      buf_load_s    = 1'b0;
      buf_clear_s   = 1'b0;
      if (lsu_valid) begin
         grant_valid_s = 1'b1;
         grant_rd_s    = lsu_rd;
         grant_data_s  = lsu_data;
         // A losing ALU result is parked. It is only accepted when the buffer is empty.
         buf_load_s    = alu_valid & ~buf_valid_r;
      end else if (buf_valid_r) begin
         grant_valid_s = 1'b1;
         grant_rd_s    = buf_rd_r;
         grant_data_s  = buf_data_r;
         buf_clear_s   = 1'b1;
      end else if (alu_valid) begin
         grant_valid_s = 1'b1;
         grant_rd_s    = alu_rd;
         grant_data_s  = alu_data;
      end else begin
         grant_valid_s = 1'b0;
      end
   end

   // Scoreboard update. The set is applied after the clear so that a same-cycle set wins. x0 is never tracked.
   always_comb begin
      set_mask_s = {NREG{1'b0}};
      clr_mask_s = {NREG{1'b0}};
      if (ld_issue && (ld_issue_rd != ZERO_RD)) begin
         set_mask_s = BIT0 << ld_issue_rd;
      end else begin
         set_mask_s = {NREG{1'b0}};
      end
      if (lsu_valid) begin
         clr_mask_s = BIT0 << lsu_rd;
      end else begin
         clr_mask_s = {NREG{1'b0}};
      end
      pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~BIT0;
   end

   // Hazard sources per read port: outstanding load, parked result, result in the output register.
   always_comb begin
      pend1_s = (rs1 != ZERO_RD) && pending_r[rs1];
      pend2_s = (rs2 != ZERO_RD) && pending_r[rs2];
      buf1_s  = (rs1 != ZERO_RD) && buf_valid_r && (buf_rd_r == rs1);
      buf2_s  = (rs2 != ZERO_RD) && buf_valid_r && (buf_rd_r == rs2);
      out1_s  = (rs1 != ZERO_RD) && reg_write && (rd == rs1);
      out2_s  = (rs2 != ZERO_RD) && reg_write && (rd == rs2);
   end

`ifdef RF_WB_FWD_EN
   // Forwarding network. The buffer is younger than the output register, so it takes precedence.
   always_comb begin
      stall      = pend1_s | pend2_s;
      fwd1_valid = buf1_s | out1_s;
      fwd2_valid = buf2_s | out2_s;
      if (buf1_s) begin
         fwd1_data = buf_data_r;
      end else if (out1_s) begin
         fwd1_data = dist1;
      end else begin
         fwd1_data = {XLEN{1'b0}};
      end
      if (buf2_s) begin
         fwd2_data = buf_data_r;
      end else if (out2_s) begin
         fwd2_data = dist1;
      end else begin
         fwd2_data = {XLEN{1'b0}};
      end
   end
`else
   // Without forwarding, any not-yet-written value stalls decode.
   always_comb begin
      stall = pend1_s | pend2_s | buf1_s | buf2_s | out1_s | out2_s;
   end
`endif

   // State registers: write port, holding buffer and pending vector.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         reg_write   <= 1'b0;
         rd          <= ZERO_RD;
         dist1       <= {XLEN{1'b0}};
         buf_valid_r <= 1'b0;
         buf_rd_r    <= ZERO_RD;
         buf_data_r  <= {XLEN{1'b0}};
         pending_r   <= {NREG{1'b0}};
      end else begin
         // A grant to x0 is consumed but does not write.
         reg_write <= grant_valid_s && (grant_rd_s != ZERO_RD);
         if (grant_valid_s) begin
            rd    <= grant_rd_s;
            dist1 <= grant_data_s;
         end else begin
            rd    <= rd;
            dist1 <= dist1;
         end
         if (buf_load_s) begin
            buf_valid_r <= 1'b1;
            buf_rd_r    <= alu_rd;
            buf_data_r  <= alu_data;
         end else if (buf_clear_s) begin
            buf_valid_r <= 1'b0;
         end else begin
            buf_valid_r <= buf_valid_r;
         end
         pending_r <= pending_next_s;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter. A behavioural model holds waiting
// ALU results in a FIFO queue, the write port as last-write fields, and
// outstanding loads as a bit per register. Directed sequences exercise the
// listed scenarios. A randomized run follows. Build with RF_WB_FWD_EN to
// cover forwarding.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        alu_valid, lsu_valid, ld_issue;
   logic [4:0]  alu_rd, lsu_rd, ld_issue_rd, rs1, rs2;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, stall, reg_write;
   logic [4:0]  rd;
   logic [31:0] dist1;
`ifdef RF_WB_FWD_EN
   logic        fwd1_valid, fwd2_valid;
   logic [31:0] fwd1_data, fwd2_data;
`endif

   rf_wb_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .rs1(rs1), .rs2(rs2), .stall(stall),
`ifdef RF_WB_FWD_EN
      .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
      .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
      .rd(rd), .dist1(dist1), .reg_write(reg_write)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model state
   typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
   wb_t         waitq[$];   // ALU results accepted but not yet written
   bit          pend[32];   // registers with outstanding loads
   bit          m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   bit          last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      waitq.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; last_acc = 1'b0;
   endfunction

   // Value of register r not yet in the register file: 0 none, 1 load, 2 queued/output.
   function automatic int m_hit(input logic [4:0] r);
      if (r == 5'd0) return 0;
      if (pend[r]) return 1;
      foreach (waitq[i]) if (waitq[i].rd == r) return 2;
      if (m_we && m_rd == r) return 2;
      return 0;
   endfunction

`ifdef RF_WB_FWD_EN
   function automatic logic [31:0] m_fwd(input logic [4:0] r);
      for (int i = waitq.size() - 1; i >= 0; i--) if (waitq[i].rd == r) return waitq[i].data;
      return m_data;
   endfunction
`endif

   task automatic compare_outputs();
      int h1, h2;
      h1 = m_hit(rs1);
      h2 = m_hit(rs2);
      check("alu_ready", {31'd0, alu_ready}, {31'd0, waitq.size() == 0});
      check("reg_write", {31'd0, reg_write}, {31'd0, m_we});
      if (m_we) begin
         check("rd", {27'd0, rd}, {27'd0, m_rd});
         check("dist1", dist1, m_data);
      end
`ifdef RF_WB_FWD_EN
      check("stall", {31'd0, stall}, {31'd0, (h1 == 1) || (h2 == 1)});
      check("fwd1_valid", {31'd0, fwd1_valid}, {31'd0, h1 == 2});
      check("fwd2_valid", {31'd0, fwd2_valid}, {31'd0, h2 == 2});
      if (h1 == 2) check("fwd1_data", fwd1_data, m_fwd(rs1));
      if (h2 == 2) check("fwd2_data", fwd2_data, m_fwd(rs2));
`else
      check("stall", {31'd0, stall}, {31'd0, (h1 != 0) || (h2 != 0)});
`endif
   endtask

   // Apply the arbitration rules for one clock edge.
   function automatic void model_edge();
      bit   acc, g;
      wb_t  w;
      acc = alu_valid && (waitq.size() == 0);
      g = 1'b1;
      if (lsu_valid) begin
         w.rd = lsu_rd; w.data = lsu_data;
         if (acc) waitq.push_back('{alu_rd, alu_data});
      end else if (waitq.size() > 0) begin
         w = waitq.pop_front();
      end else if (alu_valid) begin
         w.rd = alu_rd; w.data = alu_data;
      end else begin
         g = 1'b0;
      end
      m_we = g && (w.rd != 5'd0);
      if (m_we) begin m_rd = w.rd; m_data = w.data; end
      if (lsu_valid) pend[lsu_rd] = 1'b0;
      if (ld_issue && ld_issue_rd != 5'd0) pend[ld_issue_rd] = 1'b1;
      last_acc = acc;
   endfunction

   task automatic step();
      @(negedge CLK);
      compare_outputs();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      ld_issue = 1'b0; ld_issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      rs1 = 5'd5;
      #1;
      check("reset_reg_write", {31'd0, reg_write}, 32'd0);
      check("reset_rd", {27'd0, rd}, 32'd0);
      check("reset_dist1", dist1, 32'd0);
      check("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("reset_stall", {31'd0, stall}, 32'd0);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      // Single ALU result to x3
      idle_inputs();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      step();
      idle_inputs(); rs1 = 5'd3;
      check("alu_wb_rd", {27'd0, rd}, 32'd3);
      check("alu_wb_data", dist1, 32'h11);
      step();
      step();

      // LSU and ALU collide: LSU first, ALU one cycle later
      idle_inputs();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hAA;
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hBB;
      step();
      idle_inputs();
      #1;
      check("collide_rd_lsu", {27'd0, rd}, 32'd7);
      check("collide_data_lsu", dist1, 32'hAA);
      check("collide_alu_ready", {31'd0, alu_ready}, 32'd0);
      step();
      check("collide_rd_alu", {27'd0, rd}, 32'd8);
      check("collide_data_alu", dist1, 32'hBB);
      step();

      // Load to x9 with rs2 waiting on it
      idle_inputs();
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      step();
      idle_inputs(); rs2 = 5'd9;
      repeat (3) step();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999;
      step();
      lsu_valid = 1'b0;
      repeat (2) step();

      // Same-cycle set and clear of x4; ALU write to x0
      idle_inputs();
      ld_issue = 1'b1; ld_issue_rd = 5'd4;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
      step();
      idle_inputs();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
      step();
      idle_inputs(); rs1 = 5'd4;
      #1;
      check("x4_still_pending", {31'd0, stall}, 32'd1);
      check("x0_no_write", {31'd0, reg_write}, 32'd0);
      step();
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444;
      step();
      idle_inputs();
      repeat (2) step();

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         if (!alu_valid || last_acc) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         lsu_valid   = ($urandom_range(0, 9) < 5);
         lsu_rd      = 5'($urandom_range(0, 7));
         lsu_data    = $urandom;
         ld_issue    = ($urandom_range(0, 9) < 3);
         ld_issue_rd = 5'($urandom_range(0, 7));
         rs1         = 5'($urandom_range(0, 7));
         rs2         = 5'($urandom_range(0, 7));
         step();
      end

      // Asynchronous reset with the buffer full and x5 pending
      idle_inputs();
      repeat (2) step();
      ld_issue = 1'b1; ld_issue_rd = 5'd5;
      lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h1;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
      step();
      idle_inputs(); rs1 = 5'd5;
      #1;
      check("pre_reset_alu_ready", {31'd0, alu_ready}, 32'd0);
      check("pre_reset_stall", {31'd0, stall}, 32'd1);
      RST_N = 1'b0;
      #1;
      check("async_reg_write", {31'd0, reg_write}, 32'd0);
      check("async_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("async_stall", {31'd0, stall}, 32'd0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
